// File: rtl/lut_neuron_prog.sv
// Programmable truth-table neuron: a 2^IN_BITS-entry lookup table, cleared by an
// init sweep after reset, rewritten over a config port, read through a 2-stage valid/ready pipe.
`timescale 1ns/1ps
module lut_neuron_prog #(
  parameter int IN_BITS     = 8,
  parameter int OUT_BITS    = 1,
  parameter int DEFAULT_OUT = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_BITS-1:0]  M0,
  input  logic                M0_valid,
  output logic                M0_ready,
  output logic [OUT_BITS-1:0] M1,
  output logic                M1_valid,
  input  logic                M1_ready,
  input  logic                cfg_we,
  input  logic [IN_BITS-1:0]  cfg_addr,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_drop,
  output logic                init_done
);

  localparam int DEPTH = 1 << IN_BITS;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IN_BITS-1:0]  r_clr_cnt;
  logic [OUT_BITS-1:0] r_table [DEPTH];
  logic                r_cfg_drop;

  logic [IN_BITS-1:0]  r_s1_addr;
  logic                r_v1;
  logic [OUT_BITS-1:0] r_m1;
  logic                r_m1_valid;

  logic                w_advance;
  logic                w_m0_ready;
  logic                w_load;
  logic [OUT_BITS-1:0] w_rd_data;

  // Next-state decode: leave INIT once the last table entry has been cleared.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_clr_cnt == {IN_BITS{1'b1}}) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // State register, clear counter and discarded-write flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_clr_cnt  <= {IN_BITS{1'b0}};
      r_cfg_drop <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cfg_drop <= (r_state == ST_INIT) && cfg_we;
      if (r_state == ST_INIT) begin
        r_clr_cnt <= r_clr_cnt + {{(IN_BITS-1){1'b0}}, 1'b1};
      end else begin
        r_clr_cnt <= r_clr_cnt;
      end
    end
  end

  // Table storage is deliberately unreset so it can map to distributed RAM; INIT clears it.
  always_ff @(posedge clk) begin
    if (r_state == ST_INIT) begin
      r_table[r_clr_cnt] <= OUT_BITS'(DEFAULT_OUT);
    end else if (cfg_we) begin
      r_table[cfg_addr] <= cfg_data;
    end
  end

  assign w_rd_data  = r_table[r_s1_addr];
  assign w_advance  = !r_m1_valid || M1_ready;
  assign w_m0_ready = (r_state == ST_RUN) && (!r_v1 || w_advance);
  assign w_load     = M0_valid && w_m0_ready;

  // S1 holds the address; the table is read only when it moves on, so stalled entries see late writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_addr <= {IN_BITS{1'b0}};
      r_v1      <= 1'b0;
    end else if (w_load) begin
      r_s1_addr <= M0;
      r_v1      <= 1'b1;
    end else if (r_v1 && w_advance) begin
      r_s1_addr <= r_s1_addr;
      r_v1      <= 1'b0;
    end else begin
      r_s1_addr <= r_s1_addr;
      r_v1      <= r_v1;
    end
  end

  // S2 output register: holds while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m1       <= {OUT_BITS{1'b0}};
      r_m1_valid <= 1'b0;
    end else if (w_advance) begin
      r_m1_valid <= r_v1;
      if (r_v1) begin
        r_m1 <= w_rd_data;
      end else begin
        r_m1 <= r_m1;
      end
    end else begin
      r_m1       <= r_m1;
      r_m1_valid <= r_m1_valid;
    end
  end

  assign M0_ready  = w_m0_ready;
  assign M1        = r_m1;
  assign M1_valid  = r_m1_valid;
  assign cfg_drop  = r_cfg_drop;
  assign init_done = (r_state == ST_RUN);

endmodule
